// File: rtl/bsg_comm_link_chan_tx.sv
// rtl/bsg_comm_link_chan_tx.sv - comm-link channel transmitter with credit flow control
// Optional link training enabled by defining BSG_COMM_LINK_TX_TRAIN_EN.
module bsg_comm_link_chan_tx #(
    parameter int width_p                = 32,
    parameter int channel_width_p        = 8,
    parameter int credits_p              = 16,
    parameter int lg_credit_decimation_p = 2,
    parameter int train_cycles_p         = 64
) (
    input  logic                           clk_i,
    input  logic                           async_reset_i,
    input  logic [width_p-1:0]             data_i,
    input  logic                           v_i,
    output logic                           ready_o,
    output logic                           clk_tline_o,
    output logic                           valid_tline_o,
    output logic [channel_width_p-1:0]     data_tline_o,
    input  logic                           token_clk_tline_i,
    output logic [$clog2(credits_p+1)-1:0] credits_o,
    output logic                           error_o
);

    localparam int beats_lp  = width_p / channel_width_p;
    localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int cred_w_lp = $clog2(credits_p + 1);
    localparam int sum_w_lp  = cred_w_lp + lg_credit_decimation_p + 2;

    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(beats_lp - 1);
    localparam logic [sum_w_lp-1:0]  dec_lp       = sum_w_lp'(2 ** lg_credit_decimation_p);
    localparam logic [sum_w_lp-1:0]  max_lp       = sum_w_lp'(credits_p);

`ifdef BSG_COMM_LINK_TX_TRAIN_EN
    localparam int train_w_lp = $clog2(train_cycles_p + 1);
    localparam logic [channel_width_p-1:0] pat_a_lp = {(channel_width_p/2){2'b10}};
    localparam logic [channel_width_p-1:0] pat_5_lp = {(channel_width_p/2){2'b01}};

    typedef enum logic [1:0] {TRAIN, IDLE, SEND} state_e;
    localparam state_e reset_state_lp = TRAIN;

    logic [train_w_lp-1:0] train_cnt;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_e;
    localparam state_e reset_state_lp = IDLE;
`endif

    state_e                 state_r, state_n;
    logic [beat_w_lp-1:0]   beat_r, beat_n;
    logic [width_p-1:0]     shift_r;
    logic                   sync1_r, sync2_r, sync3_r, token_edge;
    logic                   hs, ovf, ready_n;
    logic [sum_w_lp-1:0]    cred_sum;
    logic [cred_w_lp-1:0]   cred_n;

    always_comb begin
        hs       = v_i & ready_o;
        // Token return and handshake land in the same cycle as a net change.
        cred_sum = {{(sum_w_lp-cred_w_lp){1'b0}}, credits_o}
                 + (token_edge ? dec_lp : '0)
                 - {{(sum_w_lp-1){1'b0}}, hs};
        ovf      = cred_sum > max_lp;
        cred_n   = ovf ? cred_w_lp'(credits_p) : cred_sum[cred_w_lp-1:0];

        state_n = state_r;
        beat_n  = beat_r;
        case (state_r)
`ifdef BSG_COMM_LINK_TX_TRAIN_EN
            TRAIN: if (train_cnt == train_w_lp'(train_cycles_p)) state_n = IDLE;
`endif
            IDLE: begin
                if (hs) begin
                    state_n = SEND;
                    beat_n  = '0;
                end
            end
            SEND: begin
                if (hs)                         beat_n  = '0;
                else if (beat_r == last_beat_lp) state_n = IDLE;
                else                            beat_n  = beat_r + 1'b1;
            end
            default: state_n = reset_state_lp;
        endcase

        // Registered ready: true in reset-free cycles exactly when the FSM can take a word.
        ready_n = ((state_n == IDLE) || (state_n == SEND && beat_n == last_beat_lp))
                  && (cred_n != '0);
    end

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            state_r       <= reset_state_lp;
            beat_r        <= '0;
            shift_r       <= '0;
            sync1_r       <= 1'b0;
            sync2_r       <= 1'b0;
            sync3_r       <= 1'b0;
            token_edge    <= 1'b0;
            ready_o       <= 1'b0;
            clk_tline_o   <= 1'b0;
            valid_tline_o <= 1'b0;
            data_tline_o  <= '0;
            credits_o     <= cred_w_lp'(credits_p);
            error_o       <= 1'b0;
`ifdef BSG_COMM_LINK_TX_TRAIN_EN
            train_cnt     <= '0;
`endif
        end else begin
            state_r     <= state_n;
            beat_r      <= beat_n;
            ready_o     <= ready_n;
            credits_o   <= cred_n;
            error_o     <= error_o | ovf;
            clk_tline_o <= ~clk_tline_o;

            sync1_r    <= token_clk_tline_i;
            sync2_r    <= sync1_r;
            sync3_r    <= sync2_r;
            token_edge <= sync2_r & ~sync3_r;

            if (hs) begin
                data_tline_o  <= data_i[channel_width_p-1:0];
                shift_r       <= data_i >> channel_width_p;
                valid_tline_o <= 1'b1;
            end else if (state_r == SEND && beat_r != last_beat_lp) begin
                data_tline_o  <= shift_r[channel_width_p-1:0];
                shift_r       <= shift_r >> channel_width_p;
                valid_tline_o <= 1'b1;
            end
`ifdef BSG_COMM_LINK_TX_TRAIN_EN
            else if (state_r == TRAIN) begin
                valid_tline_o <= 1'b0;
                if (train_cnt != train_w_lp'(train_cycles_p)) begin
                    data_tline_o <= train_cnt[0] ? pat_5_lp : pat_a_lp;
                    train_cnt    <= train_cnt + 1'b1;
                end
            end
`endif
            else begin
                valid_tline_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bsg_comm_link_chan_tx.sv
// tb/tb_bsg_comm_link_chan_tx.sv - randomized self-checking bench for bsg_comm_link_chan_tx
module tb_bsg_comm_link_chan_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data = '0;
    logic        v = 1'b0;
    logic        ready;
    logic        clk_tline;
    logic        valid_tline;
    logic [7:0]  data_tline;
    logic        token = 1'b0;
    logic [4:0]  credits;
    logic        error_flag;

    always #5 clk = ~clk;

    bsg_comm_link_chan_tx #(
        .width_p(32), .channel_width_p(8), .credits_p(16),
        .lg_credit_decimation_p(2), .train_cycles_p(64)
    ) dut (
        .clk_i(clk), .async_reset_i(rst), .data_i(data), .v_i(v), .ready_o(ready),
        .clk_tline_o(clk_tline), .valid_tline_o(valid_tline), .data_tline_o(data_tline),
        .token_clk_tline_i(token), .credits_o(credits), .error_o(error_flag)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending beats in order, credit count, scheduled token arrivals.
    logic [7:0]  exp_q[$];
    int          arr[$];
    int          cred_m;
    bit          err_m, clk_m, ready_m, hs_pend;
    logic [7:0]  last_m;
    logic [31:0] hs_word;
    int          cyc = 0;
    int          tok_timer = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        arr.delete();
        cred_m    = 16;
        err_m     = 0;
        clk_m     = 0;
        ready_m   = 0;
        hs_pend   = 0;
        last_m    = 8'h00;
        tok_timer = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (hs_pend) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(hs_word[8*k +: 8]);
            cred_m--;
            hs_pend = 0;
        end
        while (arr.size() > 0 && arr[0] == cyc) begin
            void'(arr.pop_front());
            cred_m += 4;
        end
        if (cred_m > 16) begin
            cred_m = 16;
            err_m  = 1;
        end
        clk_m = ~clk_m;
        check("clk_tline", clk_tline, clk_m);
        if (exp_q.size() > 0) begin
            last_m = exp_q.pop_front();
            check("valid", valid_tline, 1);
            check("data", data_tline, last_m);
        end else begin
            check("valid", valid_tline, 0);
            check("data_hold", data_tline, last_m);
        end
        ready_m = (exp_q.size() == 0) && (cred_m > 0);
        check("ready", ready, ready_m);
        check("credits", credits, cred_m);
        check("error", error_flag, err_m);
    endtask

    task automatic drive(input bit vv, input logic [31:0] d, input bit want_tok);
        v    = vv;
        data = d;
        if (vv && ready_m) begin
            hs_pend = 1;
            hs_word = d;
        end
        // Token pulses: high two cycles, low at least two, so the synchronizer sees every edge.
        if (tok_timer > 0) tok_timer--;
        if (tok_timer == 0 && want_tok) begin
            token     = 1'b1;
            tok_timer = 4;
            arr.push_back(cyc + 4);
        end else if (tok_timer <= 2) begin
            token = 1'b0;
        end
    endtask

    task automatic run_phase(input int n, input int pv, input int pt);
        for (int i = 0; i < n; i++) begin
            tick();
            drive($urandom_range(99) < pv, $urandom, $urandom_range(99) < pt);
        end
    endtask

    task automatic do_reset();
        v     = 1'b0;
        token = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_clk_tline", clk_tline, 0);
        check("rst_valid", valid_tline, 0);
        check("rst_data", data_tline, 0);
        check("rst_ready", ready, 0);
        check("rst_credits", credits, 16);
        check("rst_error", error_flag, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
`ifdef BSG_COMM_LINK_TX_TRAIN_EN
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cyc++;
            clk_m  = ~clk_m;
            last_m = (i % 2 == 0) ? 8'hAA : 8'h55;
            check("train_clk", clk_tline, clk_m);
            check("train_valid", valid_tline, 0);
            check("train_ready", ready, 0);
            check("train_data", data_tline, last_m);
        end
`endif
    endtask

    initial begin
        bit found;
        model_reset();
        do_reset();

        // Single known word.
        tick();
        drive(1, 32'h44332211, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(0, $urandom, 0);
        end
        check("first_word_credits", credits, 15);

        // Drain all credits with continuous traffic.
        run_phase(80, 100, 0);
        check("drained_credits", credits, 0);
        check("drained_ready", ready, 0);

        // One token returns four credits.
        tick();
        drive(1, $urandom, 1);
        run_phase(40, 100, 0);
        check("token_credits", credits, 0);

        // Mixed traffic with credit returns.
        run_phase(2000, 70, 25);

        // Flood tokens to force saturation.
        run_phase(60, 0, 100);
        check("sat_credits", credits, 16);
        check("sat_error", error_flag, 1);
        run_phase(10, 0, 0);

        // Reset in the middle of a word.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (exp_q.size() == 1) found = 1;
            else drive(1, $urandom, 0);
        end
        check("reach_beat2", found, 1);
        do_reset();

        run_phase(400, 60, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
